intp_cfg_master: RTL and testbench

APB requester that programs the interrupt controller's per-peripheral priority registers from a packed priority table. It can optionally read back each register and compare it. It sits between the boot/config logic and the interrupt controller's APB slave port, sequencing one setup/access transfer pair per register. It reports completion, slave errors, timeouts and readback mismatches.

---
 rtl/intp_cfg_master_if.sv | 25 ++
 rtl/intp_cfg_master.sv | 161 ++++++++++++++++
 tb/tb_intp_cfg_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intp_cfg_master_if.sv
// APB requester-side bundle between intp_cfg_master and the interrupt
// controller's priority-register slave port.
interface intp_cfg_master_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;
    logic                  perror_i;

    modport master (
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
        input  prdata_i, pready_i, perror_i
    );

    modport slave (
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
        output prdata_i, pready_i, perror_i
    );
endinterface

// File: rtl/intp_cfg_master.sv
// Programs the interrupt controller priority registers over APB from a packed
// table, with optional readback compare, slave-error and timeout reporting.
module intp_cfg_master #(
    parameter int unsigned NUM_OF_PERIPHERALS = 16,
    parameter int unsigned ADDR_WIDTH         = 4,
    parameter int unsigned DATA_WIDTH         = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 15
) (
    input  logic                                   pclk_i,
    input  logic                                   prst_i,
    input  logic                                   start_i,
    input  logic                                   verify_i,
    input  logic [NUM_OF_PERIPHERALS*DATA_WIDTH-1:0] prio_table_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [1:0]                             err_code_o,
    output logic [ADDR_WIDTH-1:0]                  err_addr_o,
    intp_cfg_master_if.master                      apb
);
    localparam int unsigned TBL_W = NUM_OF_PERIPHERALS * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_SLAVE    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_MISMATCH = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_ACCESS = 3'd2,
        R_SETUP  = 3'd3,
        R_ACCESS = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [TBL_W-1:0]        tbl, tbl_nxt;
    logic                    verify, verify_nxt;
    logic [1:0]              err_code_nxt;
    logic [ADDR_WIDTH-1:0]   err_addr_nxt;

    logic                    bus_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt;
    logic                    busy_nxt, done_nxt;

    function automatic logic [DATA_WIDTH-1:0] entry_of(input logic [TBL_W-1:0] t,
                                                       input logic [ADDR_WIDTH-1:0] i);
        return t[int'(i)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // State, captured run context and registered bus/status outputs
    always_ff @(posedge pclk_i) begin
        if (!prst_i) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            tbl           <= '0;
            verify        <= 1'b0;
            err_code_o    <= ERR_NONE;
            err_addr_o    <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            apb.psel_o    <= 1'b0;
            apb.penable_o <= 1'b0;
            apb.pwrite_o  <= 1'b0;
            apb.paddr_o   <= '0;
            apb.pwdata_o  <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            cnt           <= cnt_nxt;
            tbl           <= tbl_nxt;
            verify        <= verify_nxt;
            err_code_o    <= err_code_nxt;
            err_addr_o    <= err_addr_nxt;
            busy_o        <= busy_nxt;
            done_o        <= done_nxt;
            apb.psel_o    <= psel_nxt;
            apb.penable_o <= penable_nxt;
            apb.pwrite_o  <= pwrite_nxt;
            apb.paddr_o   <= paddr_nxt;
            apb.pwdata_o  <= pwdata_nxt;
        end
    end

    // Next-state sequencing; outputs are derived from the next state so they
    // line up with the state register
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        tbl_nxt      = tbl;
        verify_nxt   = verify;
        err_code_nxt = err_code_o;
        err_addr_nxt = err_addr_o;

        case (state)
            IDLE: begin
                if (start_i) begin
                    tbl_nxt      = prio_table_i;
                    verify_nxt   = verify_i;
                    err_code_nxt = ERR_NONE;
                    err_addr_nxt = '0;
                    idx_nxt      = '0;
                    state_nxt    = W_SETUP;
                end
            end
            W_SETUP: begin
                cnt_nxt   = '0;
                state_nxt = W_ACCESS;
            end
            R_SETUP: begin
                cnt_nxt   = '0;
                state_nxt = R_ACCESS;
            end
            W_ACCESS, R_ACCESS: begin
                if (apb.pready_i) begin
                    if (apb.perror_i) begin
                        err_code_nxt = ERR_SLAVE;
                        err_addr_nxt = idx;
                        state_nxt    = DONE;
                    end else if (state == R_ACCESS && apb.prdata_i != entry_of(tbl, idx)) begin
                        err_code_nxt = ERR_MISMATCH;
                        err_addr_nxt = idx;
                        state_nxt    = DONE;
                    end else if (state == W_ACCESS && verify) begin
                        state_nxt = R_SETUP;
                    end else if (idx == ADDR_WIDTH'(NUM_OF_PERIPHERALS - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = W_SETUP;
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_code_nxt = ERR_TIMEOUT;
                    err_addr_nxt = idx;
                    state_nxt    = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bus_nxt     = (state_nxt == W_SETUP) || (state_nxt == W_ACCESS) ||
                      (state_nxt == R_SETUP) || (state_nxt == R_ACCESS);
        psel_nxt    = bus_nxt;
        penable_nxt = (state_nxt == W_ACCESS) || (state_nxt == R_ACCESS);
        pwrite_nxt  = (state_nxt == W_SETUP) || (state_nxt == W_ACCESS);
        paddr_nxt   = bus_nxt ? idx_nxt : '0;
        pwdata_nxt  = pwrite_nxt ? entry_of(tbl_nxt, idx_nxt) : '0;
        busy_nxt    = (state_nxt != IDLE);
        done_nxt    = (state_nxt == DONE);
    end
endmodule

// File: tb/tb_intp_cfg_master.sv
// Directed bench for intp_cfg_master with a small APB slave that echoes writes
// and can be told to stall, error or corrupt a readback.
module tb_intp_cfg_master;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 4;

    logic            clk = 1'b0;
    logic            prst = 1'b0;
    logic            start = 1'b0;
    logic            verify = 1'b0;
    logic [N*DW-1:0] prio_table = '0;
    logic            busy, done;
    logic [1:0]      err_code;
    logic [AW-1:0]   err_addr;

    int n_cmp = 0;
    int n_err = 0;

    // slave knobs
    logic          stall_en = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    int            rise_at = 0;
    logic          perr_en = 1'b0;
    logic [AW-1:0] perr_addr = '0;
    logic          bad_en = 1'b0;
    logic [AW-1:0] bad_addr = '0;

    logic [DW-1:0] mem [0:N-1];
    int            acc_cnt = 0;

    // transfer log and running counters
    logic          log_wr   [0:1023];
    logic [AW-1:0] log_addr [0:1023];
    logic [DW-1:0] log_data [0:1023];
    int            log_n = 0;
    int            psel_total = 0;
    int            done_total = 0;

    intp_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    intp_cfg_master #(
        .NUM_OF_PERIPHERALS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)
    ) dut (
        .pclk_i       (clk),
        .prst_i       (prst),
        .start_i      (start),
        .verify_i     (verify),
        .prio_table_i (prio_table),
        .busy_o       (busy),
        .done_o       (done),
        .err_code_o   (err_code),
        .err_addr_o   (err_addr),
        .apb          (apb)
    );

    always #5 clk = ~clk;

    logic in_access, stalled;
    assign in_access    = apb.psel_o && apb.penable_o;
    assign stalled      = stall_en && in_access && apb.pwrite_o && apb.paddr_o == stall_addr;
    assign apb.pready_i = !stalled || (rise_at != 0 && acc_cnt == rise_at - 1);
    assign apb.perror_i = perr_en && in_access && apb.pwrite_o && apb.paddr_o == perr_addr;
    assign apb.prdata_i = (bad_en && !apb.pwrite_o && apb.paddr_o == bad_addr) ? 4'hF
                                                                               : mem[apb.paddr_o];

    always @(posedge clk) begin
        if (in_access && !apb.pready_i) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (in_access && apb.pready_i) begin
            if (apb.pwrite_o) mem[apb.paddr_o] <= apb.pwdata_o;
            log_wr[log_n]   <= apb.pwrite_o;
            log_addr[log_n] <= apb.paddr_o;
            log_data[log_n] <= apb.pwrite_o ? apb.pwdata_o : apb.prdata_i;
            log_n           <= log_n + 1;
        end
        if (apb.psel_o) psel_total <= psel_total + 1;
        if (done)       done_total <= done_total + 1;
    end

    function automatic logic [N*DW-1:0] make_table(input int mode);
        logic [N*DW-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++)
            t[i*DW +: DW] = (mode == 0) ? DW'(i) : DW'(N - 1 - i);
        return t;
    endfunction

    // Start a run from a negedge; returns the cycle (1 = first after accept) of done_o, 0 if none
    task automatic run(input logic vfy, input logic [N*DW-1:0] tbl, input int budget,
                       input int restart_at, output int done_cyc);
        done_cyc = 0;
        @(negedge clk);
        start = 1'b1; verify = vfy; prio_table = tbl;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start      = (k == restart_at);
            prio_table = ~tbl;
            verify     = ~vfy;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        prst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, err_code, err_addr} !== 8'h00) begin
            n_err++; $display("FAIL reset_status: got %b expected 0", {busy, done, err_code, err_addr});
        end
        n_cmp++;
        if ({apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o, apb.pwdata_o} !== 11'h0) begin
            n_err++; $display("FAIL reset_bus: got %b expected 0",
                              {apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o, apb.pwdata_o});
        end
        prst = 1'b1;
    endtask

    task automatic test_write_only();
        int dc, lb, pb, bad;
        logic [N*DW-1:0] t;
        t = make_table(0); lb = log_n; pb = psel_total; bad = 0;
        run(1'b0, t, 60, 0, dc);
        n_cmp++;
        if (dc !== 33) begin n_err++; $display("FAIL wr_done_cycle: got %0d expected 33", dc); end
        n_cmp++;
        if (err_code !== 2'd0) begin n_err++; $display("FAIL wr_err_code: got %0d expected 0", err_code); end
        n_cmp++;
        if (psel_total - pb !== 32) begin n_err++; $display("FAIL wr_bus_cycles: got %0d expected 32", psel_total - pb); end
        n_cmp++;
        if (log_n - lb !== 16) begin n_err++; $display("FAIL wr_xfers: got %0d expected 16", log_n - lb); end
        for (int i = 0; i < 16; i++)
            if (log_wr[lb+i] !== 1'b1 || log_addr[lb+i] !== AW'(i) || log_data[lb+i] !== DW'(i)) bad++;
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL wr_sequence: got %0d bad transfers expected 0", bad); end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL wr_idle_after: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_verify();
        int dc, lb, pb, bad;
        logic [N*DW-1:0] t;
        t = make_table(1); lb = log_n; pb = psel_total; bad = 0;
        run(1'b1, t, 100, 0, dc);
        n_cmp++;
        if (dc !== 65) begin n_err++; $display("FAIL vfy_done_cycle: got %0d expected 65", dc); end
        n_cmp++;
        if (err_code !== 2'd0) begin n_err++; $display("FAIL vfy_err_code: got %0d expected 0", err_code); end
        n_cmp++;
        if (psel_total - pb !== 64) begin n_err++; $display("FAIL vfy_bus_cycles: got %0d expected 64", psel_total - pb); end
        for (int i = 0; i < 32; i++)
            if (log_wr[lb+i] !== ((i % 2) == 0) || log_addr[lb+i] !== AW'(i / 2) ||
                log_data[lb+i] !== DW'(N - 1 - i / 2)) bad++;
        n_cmp++;
        if (bad !== 0 || log_n - lb !== 32) begin
            n_err++; $display("FAIL vfy_sequence: got %0d bad of %0d expected 0 of 32", bad, log_n - lb);
        end
    endtask

    task automatic test_mismatch();
        int dc, lb, pb, seen6;
        lb = log_n; pb = psel_total; seen6 = 0;
        bad_en = 1'b1; bad_addr = 4'd5;
        run(1'b1, make_table(0), 100, 0, dc);
        bad_en = 1'b0;
        n_cmp++;
        if (dc !== 25) begin n_err++; $display("FAIL mm_done_cycle: got %0d expected 25", dc); end
        n_cmp++;
        if (err_code !== 2'd3 || err_addr !== 4'd5) begin
            n_err++; $display("FAIL mm_err: got code %0d addr %0d expected code 3 addr 5", err_code, err_addr);
        end
        for (int i = lb; i < log_n; i++) if (log_addr[i] == 4'd6) seen6++;
        n_cmp++;
        if (seen6 !== 0 || log_n - lb !== 12) begin
            n_err++; $display("FAIL mm_no_addr6: got %0d addr6 xfers, %0d total expected 0, 12", seen6, log_n - lb);
        end
        n_cmp++;
        if (psel_total - pb !== 24) begin n_err++; $display("FAIL mm_bus_cycles: got %0d expected 24", psel_total - pb); end
    endtask

    task automatic test_timeout();
        int dc, lb, pb;
        lb = log_n; pb = psel_total;
        stall_en = 1'b1; stall_addr = 4'd3; rise_at = 0;
        run(1'b0, make_table(0), 60, 0, dc);
        n_cmp++;
        if (dc !== 23) begin n_err++; $display("FAIL to_done_cycle: got %0d expected 23", dc); end
        n_cmp++;
        if (err_code !== 2'd2 || err_addr !== 4'd3) begin
            n_err++; $display("FAIL to_err: got code %0d addr %0d expected code 2 addr 3", err_code, err_addr);
        end
        n_cmp++;
        if (psel_total - pb !== 22 || apb.psel_o !== 1'b0) begin
            n_err++; $display("FAIL to_bus: got %0d cycles psel %b expected 22 psel 0", psel_total - pb, apb.psel_o);
        end
        n_cmp++;
        if (log_n - lb !== 3) begin n_err++; $display("FAIL to_xfers: got %0d expected 3", log_n - lb); end

        // ready arriving in the 15th access cycle completes the transfer
        lb = log_n; pb = psel_total; rise_at = 15;
        run(1'b0, make_table(0), 80, 0, dc);
        stall_en = 1'b0; rise_at = 0;
        n_cmp++;
        if (dc !== 47) begin n_err++; $display("FAIL late_rdy_done_cycle: got %0d expected 47", dc); end
        n_cmp++;
        if (err_code !== 2'd0 || err_addr !== 4'd0) begin
            n_err++; $display("FAIL late_rdy_err: got code %0d addr %0d expected 0 0", err_code, err_addr);
        end
        n_cmp++;
        if (psel_total - pb !== 46 || log_n - lb !== 16) begin
            n_err++; $display("FAIL late_rdy_bus: got %0d cycles %0d xfers expected 46 16", psel_total - pb, log_n - lb);
        end
    endtask

    task automatic test_perror();
        int dc, db;
        perr_en = 1'b1; perr_addr = 4'd9;
        run(1'b0, make_table(0), 60, 5, dc);
        perr_en = 1'b0;
        n_cmp++;
        if (dc !== 21) begin n_err++; $display("FAIL perr_done_cycle: got %0d expected 21", dc); end
        n_cmp++;
        if (err_code !== 2'd1 || err_addr !== 4'd9) begin
            n_err++; $display("FAIL perr_err: got code %0d addr %0d expected code 1 addr 9", err_code, err_addr);
        end
        db = done_total;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({busy, apb.psel_o} !== 2'b00 || done_total - db !== 1 || err_code !== 2'd1) begin
            n_err++; $display("FAIL perr_after: got busy %b psel %b dones %0d code %0d expected 0 0 1 1",
                              busy, apb.psel_o, done_total - db, err_code);
        end
    endtask

    task automatic test_reset_mid();
        int dc, db, lb;
        logic [N*DW-1:0] t;
        t = make_table(1);
        @(negedge clk);
        start = 1'b1; verify = 1'b0; prio_table = t;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_cmp++;
        if ({apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o} !== 7'b1110111) begin
            n_err++; $display("FAIL rmid_pre: got %b expected 1110111",
                              {apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o});
        end
        db = done_total;
        prst = 1'b0;
        @(negedge clk);
        prst = 1'b1;
        n_cmp++;
        if ({busy, done, err_code, err_addr, apb.psel_o, apb.penable_o, apb.pwrite_o,
             apb.paddr_o, apb.pwdata_o} !== 19'h0) begin
            n_err++; $display("FAIL rmid_outputs: got busy %b done %b psel %b pen %b addr %0d expected all 0",
                              busy, done, apb.psel_o, apb.penable_o, apb.paddr_o);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done_total - db !== 0 || apb.psel_o !== 1'b0) begin
            n_err++; $display("FAIL rmid_no_done: got %0d dones psel %b expected 0 0", done_total - db, apb.psel_o);
        end
        lb = log_n;
        run(1'b0, t, 60, 0, dc);
        n_cmp++;
        if (dc !== 33 || err_code !== 2'd0) begin
            n_err++; $display("FAIL rmid_rerun: got done %0d code %0d expected 33 0", dc, err_code);
        end
        n_cmp++;
        if (log_addr[lb] !== 4'd0 || log_data[lb] !== 4'hF || log_n - lb !== 16) begin
            n_err++; $display("FAIL rmid_first_xfer: got addr %0d data %0h count %0d expected 0 f 16",
                              log_addr[lb], log_data[lb], log_n - lb);
        end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_verify();
        test_mismatch();
        test_timeout();
        test_perror();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
